// File: rtl/stereo_pkg.sv
// Shared constants and state encoding for the stereo frame feed and the
// disparity calculator's coordinate logic.
package stereo_pkg;
  localparam int PIX_W     = 3;
  localparam int X_W       = 7;
  localparam int Y_W       = 4;
  localparam int ADDR_W    = X_W + Y_W;
  localparam int IMG_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } feed_state_t;
endpackage

// File: rtl/frame_ram.sv
// Single-image store: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
module frame_ram #(
  parameter int AW = 11,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  // write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read, samples pre-write contents on a collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end
endmodule

// File: rtl/stereo_frame_feed.sv
// Frame buffer between the pixel stream and the disparity calculator.
// Loads one left/right frame pair, holds it while the calculator reads,
// then reloads after calc_done.
module stereo_frame_feed #(
  parameter int PIX_W  = stereo_pkg::PIX_W,
  parameter int X_W    = stereo_pkg::X_W,
  parameter int Y_W    = stereo_pkg::Y_W,
  parameter int ADDR_W = X_W + Y_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_f,
  input  logic [PIX_W-1:0]  pix_g,
  input  logic [ADDR_W-1:0] address_f,
  input  logic [ADDR_W-1:0] address_g,
  output logic [PIX_W-1:0]  getfdata,
  output logic [PIX_W-1:0]  gdata,
  output logic              frame_ready,
  input  logic              calc_done,
  output logic [CNT_W-1:0]  frame_count,
  output logic              sync_err
);
  import stereo_pkg::*;

  // lane 0 = left (f), lane 1 = right (g)
  localparam int NUM_LANES = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef struct packed {
    logic                            we;
    logic [ADDR_W-1:0]               addr;
    logic [NUM_LANES-1:0][PIX_W-1:0] data;
  } wr_req_t;

  feed_state_t                     state, state_nxt;
  logic [ADDR_W-1:0]               wr_addr, wr_addr_nxt;
  wr_req_t                         wr;
  logic                            frame_done;
  logic                            sof_err;
  logic [NUM_LANES-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_LANES-1:0][PIX_W-1:0]  rd_data;

  // next state, write request and sof check
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    wr          = '0;
    frame_done  = 1'b0;
    sof_err     = 1'b0;
    unique case (state)
      IDLE:  state_nxt = LOAD;
      LOAD: begin
        if (pix_valid && pix_ready) begin
          // sof always forces the beat to address 0 (resync if misplaced)
          wr.we       = 1'b1;
          wr.addr     = pix_sof ? '0 : wr_addr;
          wr.data     = {pix_g, pix_f};
          wr_addr_nxt = wr.addr + ADDR_W'(1);
          sof_err     = pix_sof && (wr_addr != '0);
          if (wr.addr == LAST_ADDR) begin
            frame_done = 1'b1;
            state_nxt  = READY;
          end
        end
      end
      READY: if (calc_done) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // state, counters and registered handshake/status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_addr     <= '0;
      pix_ready   <= 1'b0;
      frame_ready <= 1'b0;
      frame_count <= '0;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_addr     <= wr_addr_nxt;
      pix_ready   <= (state_nxt == LOAD);
      frame_ready <= (state_nxt == READY);
      if (frame_done) frame_count <= frame_count + CNT_W'(1);
      if (sof_err)    sync_err    <= 1'b1;
    end
  end

  assign rd_addr[0] = address_f;
  assign rd_addr[1] = address_g;
  assign getfdata   = rd_data[0];
  assign gdata      = rd_data[1];

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    frame_ram #(.AW(ADDR_W), .DW(PIX_W)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (wr.we),
      .waddr (wr.addr),
      .wdata (wr.data[l]),
      .raddr (rd_addr[l]),
      .rdata (rd_data[l])
    );
  end
endmodule

// File: tb/tb_stereo_frame_feed.sv
// Directed bench for stereo_frame_feed: load, readback, stall, resync,
// collision and async reset.
module tb_stereo_frame_feed;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_valid = 1'b0, pix_sof = 1'b0, calc_done = 1'b0;
  logic        pix_ready, frame_ready, sync_err;
  logic [2:0]  pix_f = '0, pix_g = '0, getfdata, gdata;
  logic [10:0] address_f = '0, address_g = '0;
  logic [7:0]  frame_count;
  int          n_cmp = 0, n_err = 0;

  stereo_frame_feed dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_f(pix_f), .pix_g(pix_g),
    .address_f(address_f), .address_g(address_g),
    .getfdata(getfdata), .gdata(gdata), .frame_ready(frame_ready),
    .calc_done(calc_done), .frame_count(frame_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic v, input logic s, input logic [2:0] f, input logic [2:0] g);
    pix_valid = v; pix_sof = s; pix_f = f; pix_g = g;
    step();
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic pulse_done();
    calc_done = 1'b1; step(); calc_done = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if ({pix_ready, frame_ready, sync_err} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {pix_ready, frame_ready, sync_err}); end
    n_cmp++; if ({frame_count, getfdata, gdata} !== 14'd0) begin n_err++; $display("FAIL rst_data got=%h exp=0", {frame_count, getfdata, gdata}); end
    step(); step(); rst = 1'b0; #1;
    n_cmp++; if (pix_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready got=%b exp=0", pix_ready); end
    step();
    n_cmp++; if ({pix_ready, frame_ready} !== 2'b10) begin n_err++; $display("FAIL load_entry got=%b exp=10", {pix_ready, frame_ready}); end
  endtask

  // frame 1: f=a[2:0], g=~a[2:0], with a bubble (carrying a stray sof) before odd beats
  task automatic test_stream();
    for (int a = 0; a < 2048; a++) begin
      if (a % 2 == 1) beat(1'b0, 1'b1, 3'd7, 3'd7);
      if (a == 2047) begin
        n_cmp++; if ({pix_ready, frame_ready} !== 2'b10) begin n_err++; $display("FAIL pre_last got=%b exp=10", {pix_ready, frame_ready}); end
      end
      beat(1'b1, a == 0, 3'(a), ~3'(a));
    end
    n_cmp++; if ({pix_ready, frame_ready} !== 2'b01) begin n_err++; $display("FAIL frame1_done got=%b exp=01", {pix_ready, frame_ready}); end
    n_cmp++; if (frame_count !== 8'd1) begin n_err++; $display("FAIL frame1_count got=%0d exp=1", frame_count); end
    n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL frame1_sync got=%b exp=0", sync_err); end
  endtask

  task automatic test_readback();
    logic [10:0] af, ag;
    address_f = 11'h405; address_g = 11'h7FF; step();
    n_cmp++; if ({getfdata, gdata} !== 6'b101_000) begin n_err++; $display("FAIL rd_fixed got=%b exp=101000", {getfdata, gdata}); end
    for (int i = 0; i < 6; i++) begin
      af = 11'(i * 301 + 7); ag = 11'(i * 177 + 3);
      address_f = af; address_g = ag; step();
      n_cmp++; if ({getfdata, gdata} !== {af[2:0], ~ag[2:0]}) begin n_err++; $display("FAIL rd_stream%0d got=%b exp=%b", i, {getfdata, gdata}, {af[2:0], ~ag[2:0]}); end
    end
  endtask

  task automatic test_ready_stall();
    for (int i = 0; i < 10; i++) beat(1'b1, 1'b0, 3'd7, 3'd7);
    n_cmp++; if ({pix_ready, frame_ready} !== 2'b01) begin n_err++; $display("FAIL stall_flags got=%b exp=01", {pix_ready, frame_ready}); end
    address_f = 11'd6; address_g = 11'd6; step();
    n_cmp++; if ({getfdata, gdata} !== 6'b110_001) begin n_err++; $display("FAIL stall_keep got=%b exp=110001", {getfdata, gdata}); end
    pulse_done();
    n_cmp++; if ({pix_ready, frame_ready} !== 2'b10) begin n_err++; $display("FAIL release got=%b exp=10", {pix_ready, frame_ready}); end
    n_cmp++; if (frame_count !== 8'd1) begin n_err++; $display("FAIL release_count got=%0d exp=1", frame_count); end
  endtask

  // frame 2 pattern: f=a^5, g=a^3; address 2 holds 010 from frame 1
  task automatic test_collision();
    beat(1'b1, 1'b1, 3'(0) ^ 3'd5, 3'(0) ^ 3'd3);
    beat(1'b1, 1'b0, 3'(1) ^ 3'd5, 3'(1) ^ 3'd3);
    address_f = 11'd2;
    beat(1'b1, 1'b0, 3'(2) ^ 3'd5, 3'(2) ^ 3'd3);
    n_cmp++; if (getfdata !== 3'b010) begin n_err++; $display("FAIL coll_old got=%b exp=010", getfdata); end
    beat(1'b1, 1'b0, 3'(3) ^ 3'd5, 3'(3) ^ 3'd3);
    n_cmp++; if (getfdata !== 3'b111) begin n_err++; $display("FAIL coll_new got=%b exp=111", getfdata); end
  endtask

  task automatic test_missync();
    for (int a = 4; a < 37; a++) beat(1'b1, 1'b0, 3'(a) ^ 3'd5, 3'(a) ^ 3'd3);
    n_cmp++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL sync_pre got=%b exp=0", sync_err); end
    beat(1'b1, 1'b1, 3'b110, 3'b001);
    n_cmp++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL sync_set got=%b exp=1", sync_err); end
    for (int a = 1; a < 2048; a++) begin
      if (a == 2047) begin
        n_cmp++; if (frame_ready !== 1'b0) begin n_err++; $display("FAIL resync_early got=%b exp=0", frame_ready); end
      end
      beat(1'b1, 1'b0, 3'(a) ^ 3'd5, 3'(a) ^ 3'd3);
    end
    n_cmp++; if ({pix_ready, frame_ready, sync_err} !== 3'b011) begin n_err++; $display("FAIL resync_done got=%b exp=011", {pix_ready, frame_ready, sync_err}); end
    n_cmp++; if (frame_count !== 8'd2) begin n_err++; $display("FAIL frame2_count got=%0d exp=2", frame_count); end
    address_f = 11'd0; address_g = 11'd0; step();
    n_cmp++; if ({getfdata, gdata} !== 6'b110_001) begin n_err++; $display("FAIL resync_addr0 got=%b exp=110001", {getfdata, gdata}); end
    address_f = 11'd37; address_g = 11'd37; step();
    n_cmp++; if ({getfdata, gdata} !== 6'b000_110) begin n_err++; $display("FAIL resync_addr37 got=%b exp=000110", {getfdata, gdata}); end
  endtask

  // frame 3 pattern f=a^1, g=a^4 (partial); post-reset pattern f=a^6, g=a^2
  task automatic test_async_reset();
    pulse_done();
    for (int a = 0; a < 1000; a++) beat(1'b1, a == 0, 3'(a) ^ 3'd1, 3'(a) ^ 3'd4);
    #2 rst = 1'b1; #1;
    n_cmp++; if ({pix_ready, frame_ready, sync_err} !== 3'b000) begin n_err++; $display("FAIL arst_flags got=%b exp=000", {pix_ready, frame_ready, sync_err}); end
    n_cmp++; if ({frame_count, getfdata, gdata} !== 14'd0) begin n_err++; $display("FAIL arst_data got=%h exp=0", {frame_count, getfdata, gdata}); end
    step(); rst = 1'b0; step();
    n_cmp++; if (pix_ready !== 1'b1) begin n_err++; $display("FAIL arst_reload got=%b exp=1", pix_ready); end
    pulse_done();
    n_cmp++; if ({pix_ready, frame_ready} !== 2'b10) begin n_err++; $display("FAIL done_in_load got=%b exp=10", {pix_ready, frame_ready}); end
    for (int a = 0; a < 4; a++) beat(1'b1, 1'b0, 3'(a) ^ 3'd6, 3'(a) ^ 3'd2);
    address_f = 11'd0; address_g = 11'd3; step();
    n_cmp++; if ({getfdata, gdata} !== 6'b110_001) begin n_err++; $display("FAIL restart_addr got=%b exp=110001", {getfdata, gdata}); end
    n_cmp++; if ({frame_count, sync_err} !== 9'd0) begin n_err++; $display("FAIL restart_status got=%h exp=0", {frame_count, sync_err}); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_readback();
    test_ready_stall();
    test_collision();
    test_missync();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
